pipe_collision_score: RTL and testbench

//  Downstream of the pipe mover: takes one pipe rectangle (left/right/top/bottom) and the

---
 rtl/flappy_pkg.sv | 43 ++++
 rtl/pipe_collision_score_bcd_counter3.sv | 39 +++
 rtl/pipe_collision_score.sv | 122 ++++++++++++
 tb/tb_pipe_collision_score.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Purpose: shared constants and types for the flappy game datapath (pipe mover, collision/score).
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: state encoding, playfield geometry defaults, pipe width / respawn edge, speed helper.
package flappy_pkg;

  // Game state encoding (also the value seen on the 2-bit state output)
  localparam logic [1:0] STATE_READY = 2'b00;
  localparam logic [1:0] STATE_PLAY  = 2'b01;
  localparam logic [1:0] STATE_HIT   = 2'b10;
  localparam logic [1:0] STATE_OVER  = 2'b11;

  typedef enum logic [1:0] {
    ST_READY = STATE_READY,
    ST_PLAY  = STATE_PLAY,
    ST_HIT   = STATE_HIT,
    ST_OVER  = STATE_OVER
  } game_state_t;

  // Playfield geometry defaults
  localparam logic [9:0] BIRD_X_DEF  = 10'd100;
  localparam logic [9:0] BIRD_W_DEF  = 10'd24;
  localparam logic [9:0] BIRD_H_DEF  = 10'd18;
  localparam logic [9:0] GAP_H_DEF   = 10'd80;
  localparam logic [9:0] CEIL_Y_DEF  = 10'd45;
  localparam logic [9:0] FLOOR_Y_DEF = 10'd420;
  localparam logic [7:0] HIT_TICKS_DEF = 8'd60;

  // Shared with the pipe mover: pipe width and right edge right after respawn/reset
  localparam logic [9:0] PIPE_W     = 10'd41;
  localparam logic [9:0] PIPE_RST_R = 10'd191;

  // Pipe speed from the BCD score (hundreds and tens digits only):
  // <10 -> 1, 10..29 -> 2, >=30 -> 3
  function automatic logic [1:0] speed_for_score(input logic [7:0] hund_tens);
    logic [1:0] spd;
    if (hund_tens[7:4] != 4'd0 || hund_tens[3:0] >= 4'd3) spd = 2'd3;
    else if (hund_tens[3:0] != 4'd0)                       spd = 2'd2;
    else                                                   spd = 2'd1;
    return spd;
  endfunction

endpackage

// File: rtl/pipe_collision_score_bcd_counter3.sv
// Purpose: 3-digit BCD score counter with clear and increment, saturating at 999.
// Latency: 1 game_clk; bcd_next exposes the value that will be loaded on the next edge.
// Backpressure: none; inc is ignored at 999, clr has priority over inc.
// Ports: game_clk, reset (async high), inc, clr -> bcd {hundreds,tens,ones}, bcd_next.
module bcd_counter3 (
  input  logic        game_clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [11:0] bcd,
  output logic [11:0] bcd_next
);

  always_comb begin
    bcd_next = bcd;
    if (clr) begin
      bcd_next = 12'h000;
    end else if (inc && bcd != 12'h999) begin
      if (bcd[3:0] != 4'd9) begin
        bcd_next[3:0] = bcd[3:0] + 4'd1;
      end else begin
        bcd_next[3:0] = 4'd0;
        if (bcd[7:4] != 4'd9) begin
          bcd_next[7:4] = bcd[7:4] + 4'd1;
        end else begin
          // hundreds cannot be 9 here: 999 was excluded above
          bcd_next[7:4]  = 4'd0;
          bcd_next[11:8] = bcd[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) bcd <= 12'h000;
    else       bcd <= bcd_next;
  end

endmodule

// File: rtl/pipe_collision_score.sv
// Purpose: bird/pipe collision and pass detection, BCD score, game-state FSM, pipe velocity.
// Latency: 1 game_clk from hit / flap rising edge / pass to state, score and velocity.
// Backpressure: none; velocity 0 freezes the upstream pipe mover outside PLAY.
// Ports: game_clk, reset (async high), flap, bird_y, pipe_l/r/t/b in;
//        state, velocity, score_bcd, game_over out.
module pipe_collision_score
  import flappy_pkg::*;
#(
  parameter logic [9:0] BIRD_X    = BIRD_X_DEF,
  parameter logic [9:0] BIRD_W    = BIRD_W_DEF,
  parameter logic [9:0] BIRD_H    = BIRD_H_DEF,
  parameter logic [9:0] GAP_H     = GAP_H_DEF,
  parameter logic [9:0] CEIL_Y    = CEIL_Y_DEF,
  parameter logic [9:0] FLOOR_Y   = FLOOR_Y_DEF,
  parameter logic [7:0] HIT_TICKS = HIT_TICKS_DEF
) (
  input  logic        game_clk,
  input  logic        reset,
  input  logic        flap,
  input  logic [9:0]  bird_y,
  input  logic [9:0]  pipe_l,
  input  logic [9:0]  pipe_r,
  input  logic [9:0]  pipe_t,
  input  logic [9:0]  pipe_b,
  output logic [1:0]  state,
  output logic [1:0]  velocity,
  output logic [11:0] score_bcd,
  output logic        game_over
);

  game_state_t cur_state, nxt_state;
  logic        flap_q;
  logic        flap_rise;
  logic [9:0]  pipe_r_q;
  logic [7:0]  hit_cnt, hit_cnt_nxt;
  logic [1:0]  velocity_nxt;
  logic        score_inc, score_clr;
  logic [11:0] score_nxt;

  // The upper pipe extends from pipe_t to the gap; only the gap edge matters for collision.
  logic unused_pipe_t;
  assign unused_pipe_t = ^pipe_t;

  assign flap_rise = flap & ~flap_q;

  // Overlap tests, all in 11 bits. The upper-gap test is rearranged as
  // bird_y + GAP_H < pipe_b so a small pipe_b cannot underflow.
  logic [10:0] bird_right, bird_bottom, bird_gap;
  logic        x_ov, y_ov, bound, hit, pass;

  assign bird_right  = {1'b0, BIRD_X} + {1'b0, BIRD_W};
  assign bird_bottom = {1'b0, bird_y} + {1'b0, BIRD_H};
  assign bird_gap    = {1'b0, bird_y} + {1'b0, GAP_H};

  assign x_ov  = (bird_right > {1'b0, pipe_l}) & (BIRD_X < pipe_r);
  assign y_ov  = (bird_gap < {1'b0, pipe_b}) | (bird_bottom > {1'b0, pipe_b});
  assign bound = (bird_y < CEIL_Y) | (bird_bottom > {1'b0, FLOOR_Y});
  assign hit   = (x_ov & y_ov) | bound;

  // Pipe right edge crossed the bird's left column moving left. A respawn jumps
  // from low to high, which fails the second term and is never counted.
  assign pass = (pipe_r_q >= BIRD_X) & (pipe_r < BIRD_X);

  always_comb begin
    nxt_state   = cur_state;
    hit_cnt_nxt = 8'd0;
    score_inc   = 1'b0;
    score_clr   = 1'b0;
    case (cur_state)
      ST_READY: begin
        if (flap_rise) nxt_state = ST_PLAY;
      end
      ST_PLAY: begin
        if (hit)       nxt_state = ST_HIT;
        else if (pass) score_inc = 1'b1;
      end
      ST_HIT: begin
        if (hit_cnt == HIT_TICKS - 8'd1) nxt_state = ST_OVER;
        else                             hit_cnt_nxt = hit_cnt + 8'd1;
      end
      ST_OVER: begin
        if (flap_rise) begin
          nxt_state = ST_READY;
          score_clr = 1'b1;
        end
      end
      default: nxt_state = ST_READY;
    endcase
  end

  bcd_counter3 u_score (
    .game_clk (game_clk),
    .reset    (reset),
    .inc      (score_inc),
    .clr      (score_clr),
    .bcd      (score_bcd),
    .bcd_next (score_nxt)
  );

  // Speed follows the score as updated on this same edge.
  assign velocity_nxt = (nxt_state == ST_PLAY) ? speed_for_score(score_nxt[11:4]) : 2'd0;

  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_READY;
      hit_cnt   <= 8'd0;
      velocity  <= 2'd0;
      flap_q    <= 1'b0;
      pipe_r_q  <= PIPE_RST_R;
    end else begin
      cur_state <= nxt_state;
      hit_cnt   <= hit_cnt_nxt;
      velocity  <= velocity_nxt;
      flap_q    <= flap;
      pipe_r_q  <= pipe_r;
    end
  end

  assign state     = cur_state;
  assign game_over = (cur_state == ST_OVER);

endmodule

// File: tb/tb_pipe_collision_score.sv
// Purpose: randomized + directed bench for pipe_collision_score with a scoreboard queue.
// Latency: expectations are pushed before each rising edge and popped 1 ns after it.
// Backpressure: n/a; the DUT presents outputs every tick.
module tb_pipe_collision_score;

  logic        game_clk = 1'b0;
  logic        reset;
  logic        flap;
  logic [9:0]  bird_y, pipe_l, pipe_r, pipe_t, pipe_b;
  logic [1:0]  state, velocity;
  logic [11:0] score_bcd;
  logic        game_over;

  always #5 game_clk = ~game_clk;

  pipe_collision_score dut (
    .game_clk  (game_clk),
    .reset     (reset),
    .flap      (flap),
    .bird_y    (bird_y),
    .pipe_l    (pipe_l),
    .pipe_r    (pipe_r),
    .pipe_t    (pipe_t),
    .pipe_b    (pipe_b),
    .state     (state),
    .velocity  (velocity),
    .score_bcd (score_bcd),
    .game_over (game_over)
  );

  typedef struct {
    int st;
    int vel;
    int score;
    int over;
  } exp_t;

  exp_t expq[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: game described directly by its rules, score as a plain integer.
  localparam int M_READY = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;
  int m_st, m_score, m_cnt, m_vel, m_prq, m_fq;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_READY; m_score = 0; m_cnt = 0; m_vel = 0; m_prq = 191; m_fq = 0;
  endtask

  task automatic model_push();
    exp_t e;
    e.st = m_st; e.vel = m_vel; e.score = m_score; e.over = (m_st == M_OVER) ? 1 : 0;
    expq.push_back(e);
  endtask

  // One rising edge of the game, using the inputs currently driven.
  task automatic model_edge();
    int by, pl, pr, pb;
    bit fr, hit, pass;
    by = int'(bird_y); pl = int'(pipe_l); pr = int'(pipe_r); pb = int'(pipe_b);
    fr   = (flap == 1'b1) && (m_fq == 0);
    hit  = ((124 > pl) && (100 < pr) && ((by < pb - 80) || (by + 18 > pb)))
           || (by < 45) || (by + 18 > 420);
    pass = (m_prq >= 100) && (pr < 100);
    case (m_st)
      M_READY: if (fr) m_st = M_PLAY;
      M_PLAY: begin
        if (hit) begin m_st = M_HIT; m_cnt = 0; end
        else if (pass && m_score < 999) m_score++;
      end
      M_HIT: begin
        m_cnt++;
        if (m_cnt == 60) begin m_st = M_OVER; m_cnt = 0; end
      end
      default: if (fr) begin m_st = M_READY; m_score = 0; end
    endcase
    if (m_st == M_PLAY) m_vel = (m_score < 10) ? 1 : (m_score < 30) ? 2 : 3;
    else                m_vel = 0;
    m_fq  = int'(flap);
    m_prq = pr;
    model_push();
  endtask

  task automatic step(input bit f, input int by, input int pl, input int pr, input int pb);
    @(negedge game_clk);
    reset  = 1'b0;
    flap   = f;
    bird_y = 10'(by);
    pipe_l = 10'(pl);
    pipe_r = 10'(pr);
    pipe_t = 10'd0;
    pipe_b = 10'(pb);
    model_edge();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 200, 300, 341, 250);
  endtask

  task automatic flap_pulse();
    step(1'b1, 200, 300, 341, 250);
    step(1'b0, 200, 300, 341, 250);
  endtask

  // Bird sits in the gap; pipe edge goes 101 -> 99 across the bird's column.
  task automatic pass_once();
    step(1'b0, 200, 60, 101, 250);
    step(1'b0, 200, 58, 99, 250);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     int'(state),     0);
    check({tag, "_velocity"},  int'(velocity),  0);
    check({tag, "_score"},     int'(score_bcd), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge.
  task automatic reset_mid();
    @(negedge game_clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    model_push();
    @(negedge game_clk);
    model_push();
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge game_clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("state",     int'(state),     e.st);
        check("velocity",  int'(velocity),  e.vel);
        check("score_bcd", int'(score_bcd), int'(to_bcd(e.score)));
        check("game_over", int'(game_over), e.over);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    int pr, pb, by, pl;
    bit f;
    reset = 1'b1; flap = 1'b0; bird_y = 10'd200; pipe_l = 10'd300;
    pipe_r = 10'd341; pipe_t = 10'd0; pipe_b = 10'd250;
    #1;
    check_reset_outputs("reset");
    model_reset();

    // READY -> PLAY on a flap pulse, speed 1
    idle(3);
    flap_pulse();
    idle(2);

    // one pass, then the pipe stays left of the bird: counted once
    pass_once();
    idle(3);

    // score up to 30: crosses 9->10 and 29->30 speed thresholds
    repeat (29) pass_once();

    // pass and ceiling hit on the same edge: HIT, no score
    step(1'b0, 200, 60, 101, 250);
    step(1'b0, 20, 58, 99, 250);
    idle(62);

    // OVER with flap held: one transition to READY, score cleared, no re-entry to PLAY
    repeat (4) step(1'b1, 200, 300, 341, 250);
    step(1'b0, 200, 300, 341, 250);
    flap_pulse();

    // bird above the gap while overlapping the pipe horizontally
    step(1'b0, 100, 110, 151, 250);
    idle(62);
    flap_pulse();
    flap_pulse();

    // saturate at 999
    repeat (1003) pass_once();
    idle(2);

    reset_mid();

    // randomized play: pipe drifting left with respawns, bird random-walking, random flaps
    pr = 191; pb = 250; by = 200;
    for (int i = 0; i < 3000; i++) begin
      pr -= int'($urandom_range(3, 1));
      if (pr < 10) begin
        pr = 191;
        pb = int'($urandom_range(400, 120));
      end
      by += int'($urandom_range(8, 0)) - 4;
      if (by < 30)  by = 30 + int'($urandom_range(150, 0));
      if (by > 430) by = 430 - int'($urandom_range(150, 0));
      pl = (pr > 41) ? pr - 41 : 0;
      f  = ($urandom_range(7, 0) == 0);
      step(f, by, pl, pr, pb);
    end

    @(posedge game_clk);
    #2;
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
